// File: rtl/multu_hilo.sv
// multu_hilo: iterative unsigned shift-add multiplier feeding the HI/LO pair.
// A start latches both operands. WIDTH iterations then run, one per cycle, and
// the full product is committed to HI/LO at the last iteration edge.
// HI or LO is read back combinationally through hilo_sel.
module multu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_hilo,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hilo_sel,
    output logic [WIDTH-1:0] hilo_out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH:0] acc_q,   acc_d;
    logic [2*WIDTH:0] acc_step;

    // One shift-add iteration. The upper adder is WIDTH+1 bits, so the
    // carry out of the partial-product add lands in the top accumulator bit.
    function automatic logic [2*WIDTH:0] mul_step(input logic [2*WIDTH:0] acc,
                                                  input logic [WIDTH-1:0] mcand);
        logic [WIDTH:0]   upper;
        logic [2*WIDTH:0] summed;
        upper = acc[2*WIDTH:WIDTH];
        if (acc[0]) begin
            upper = upper + {1'b0, mcand};
        end
        summed = {upper, acc[WIDTH-1:0]};
        return {1'b0, summed[2*WIDTH:1]};
    endfunction

    assign acc_step = mul_step(acc_q, mcand_q);

    // Next-state logic: start acceptance, iteration and commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                // DONE accepts a start just like IDLE, so no idle gap is needed.
                state_d = S_IDLE;
                if (we_hilo) begin
                    mcand_d = a;
                    acc_d   = {{(WIDTH + 1){1'b0}}, b};
                    cnt_d   = '0;
                    state_d = S_BUSY;
                    busy_d  = 1'b1;
                end
            end
            S_BUSY: begin
                // Starts arriving here are ignored; the core stalls on busy.
                acc_d  = acc_step;
                cnt_d  = cnt_q + CNT_W'(1);
                busy_d = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    hi_d    = acc_step[2*WIDTH-1:WIDTH];
                    lo_d    = acc_step[WIDTH-1:0];
                    cnt_d   = '0;
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state and the architectural HI/LO; reset aborts without commit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Working operands; always reloaded on a start, so they need no reset.
    always_ff @(posedge clk) begin
        mcand_q <= mcand_d;
        acc_q   <= acc_d;
    end

    assign hilo_out = hilo_sel ? lo_q : hi_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_multu_hilo.sv
// tb_multu_hilo: directed and random checks of multu_hilo against an
// arithmetic model (64-bit product of the issued operands).
module tb_multu_hilo;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         we_hilo;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         hilo_sel;
    logic [W-1:0] hilo_out;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0]   exp_hi;
    logic [W-1:0]   exp_lo;
    logic [2*W-1:0] pend;

    always #5 clk = ~clk;

    multu_hilo #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .we_hilo  (we_hilo),
        .a        (a),
        .b        (b),
        .hilo_sel (hilo_sel),
        .hilo_out (hilo_out),
        .busy     (busy),
        .done     (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] hi, output logic [W-1:0] lo);
        hilo_sel = 1'b0;
        #1;
        hi = hilo_out;
        hilo_sel = 1'b1;
        #1;
        lo = hilo_out;
    endtask

    task automatic check_hilo(input string tag);
        logic [W-1:0] hi, lo;
        read_hilo(hi, lo);
        chk({tag, " HI"}, 64'(hi), 64'(exp_hi));
        chk({tag, " LO"}, 64'(lo), 64'(exp_lo));
    endtask

    task automatic check_const(input string tag, input logic [W-1:0] chi, input logic [W-1:0] clo);
        logic [W-1:0] hi, lo;
        read_hilo(hi, lo);
        chk({tag, " HI const"}, 64'(hi), 64'(chi));
        chk({tag, " LO const"}, 64'(lo), 64'(clo));
    endtask

    // Issue a start; the model records the pending exact product.
    task automatic start_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
        a       = x;
        b       = y;
        we_hilo = 1'b1;
        pend    = (2*W)'(x) * (2*W)'(y);
        tick();
        we_hilo = 1'b0;
        chk({tag, " busy rise"}, 64'(busy), 64'(1));
        chk({tag, " done low at start"}, 64'(done), 64'(0));
    endtask

    // Wait out the operation (bounded), optionally checking retention and
    // injecting an ignored start; ends in the DONE cycle.
    task automatic finish_op(input string tag, input int inject_at, input bit check_ret);
        int nb;
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            if (check_ret) check_hilo({tag, " retention"});
            if (nb == inject_at) begin
                a       = 32'd9;
                b       = 32'd9;
                we_hilo = 1'b1;
            end
            tick();
            we_hilo = 1'b0;
            nb++;
        end
        chk({tag, " busy cycles"}, 64'(nb), 64'(32));
        chk({tag, " done pulse"}, 64'(done), 64'(1));
        exp_hi = pend[2*W-1:W];
        exp_lo = pend[W-1:0];
        check_hilo({tag, " result"});
    endtask

    task automatic settle(input string tag);
        tick();
        chk({tag, " done drop"}, 64'(done), 64'(0));
        chk({tag, " idle busy"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int ndone;
        logic [W-1:0] rx, ry;

        rst      = 1'b1;
        we_hilo  = 1'b0;
        a        = '0;
        b        = '0;
        hilo_sel = 1'b0;
        exp_hi   = '0;
        exp_lo   = '0;
        pend     = '0;

        // Reset
        tick();
        tick();
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        check_hilo("reset");
        rst = 1'b0;
        tick();

        // Basic product
        start_op("basic", 32'd7, 32'd6);
        finish_op("basic", -1, 1'b0);
        check_const("basic", 32'd0, 32'd42);
        settle("basic");

        // Maximum operands
        start_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("max", -1, 1'b0);
        check_const("max", 32'hFFFF_FFFE, 32'h0000_0001);
        settle("max");

        // Retention and ignored start
        start_op("load", 32'h0001_0000, 32'h0001_0000);
        finish_op("load", -1, 1'b0);
        check_const("load", 32'd1, 32'd0);
        settle("load");
        start_op("retain", 32'd3, 32'd5);
        finish_op("retain", 10, 1'b1);
        check_const("retain", 32'd0, 32'd15);

        // Back-to-back issue in the DONE cycle
        start_op("b2b", 32'h8000_0000, 32'd2);
        finish_op("b2b", -1, 1'b0);
        check_const("b2b", 32'd1, 32'd0);
        settle("b2b");

        // Abort at iteration 15
        start_op("abort", 32'h1234_5678, 32'h9ABC_DEF0);
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        check_hilo("abort");
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'(0));
        check_hilo("abort hold");
        start_op("redo", 32'h1234_5678, 32'h9ABC_DEF0);
        finish_op("redo", -1, 1'b0);
        check_const("redo", 32'h0B00_EA4E, 32'h242D_2080);
        settle("redo");

        // Random operands, randomly back-to-back
        for (int i = 0; i < 8; i++) begin
            rx = $urandom();
            ry = $urandom();
            if (i == 0) ry = 32'hFFFF_FFFF;
            if (i == 1) rx = 32'd0;
            start_op("rand", rx, ry);
            finish_op("rand", ($urandom_range(3) == 0) ? int'($urandom_range(30)) : -1, 1'b0);
            if ($urandom_range(1) == 1) settle("rand");
        end
        settle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
